// File: rtl/quad2joy.sv
// Quadrature steering encoder decoder: per-phase glitch filter, step decode,
// wrapping position, saturating delta and joystick-style left/right with hold timer.
module quad2joy #(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned HOLD     = 45000,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             steerA,
    input  logic             steerB,
    input  logic             clr,
    output logic [CNT_W-1:0] position,
    output logic [CNT_W-1:0] delta,
    output logic             step,
    output logic             c_left,
    output logic             c_right,
    output logic             err
);
    localparam int FC_W = 8;
    localparam int HT_W = 20;
    localparam logic [FC_W-1:0]         FC_LAST = FC_W'(FILT_LEN - 1);
    localparam logic [HT_W-1:0]         HOLD_LD = HT_W'(HOLD);
    localparam logic signed [CNT_W-1:0] S_ONE   = CNT_W'(1);
    localparam logic signed [CNT_W-1:0] D_MAX   = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic signed [CNT_W-1:0] D_MIN   = {1'b1, {(CNT_W-1){1'b0}}};

    // Position of {A,B} along the forward cycle 00->01->11->10.
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    function automatic logic signed [CNT_W-1:0] sat_step(input logic signed [CNT_W-1:0] d,
                                                         input logic up);
        if (up) return (d == D_MAX) ? d : d + S_ONE;
        return (d == D_MIN) ? d : d - S_ONE;
    endfunction

    logic [1:0]            sync1_q, sync2_q;
    logic [1:0]            filt_q, filt_d, prev_q;
    logic [1:0][FC_W-1:0]  fcnt_q, fcnt_d;
    logic [CNT_W-1:0]      pos_q, pos_d;
    logic signed [CNT_W-1:0] dlt_q, dlt_d;
    logic [HT_W-1:0]       hold_q, hold_d;
    logic                  step_q, left_q, left_d, right_q, right_d, err_q, err_d;
    logic [1:0]            phase_diff;
    logic                  fwd, rev, bad;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                fcnt_d[i] = '0;
            end else if (fcnt_q[i] == FC_LAST) begin
                filt_d[i] = sync2_q[i];
                fcnt_d[i] = '0;
            end else begin
                fcnt_d[i] = fcnt_q[i] + FC_W'(1);
            end
        end
    end

    // A distance of 2 along the cycle means both phases moved at once.
    assign phase_diff = gray_idx(filt_q) - gray_idx(prev_q);
    assign fwd        = (phase_diff == 2'd1);
    assign rev        = (phase_diff == 2'd3);
    assign bad        = (phase_diff == 2'd2);

    always_comb begin
        pos_d   = pos_q;
        dlt_d   = dlt_q;
        hold_d  = hold_q;
        left_d  = left_q;
        right_d = right_q;
        err_d   = err_q | bad;

        if (fwd)      pos_d = pos_q + CNT_W'(1);
        else if (rev) pos_d = pos_q - CNT_W'(1);

        if (clr) begin
            if (fwd)      dlt_d = S_ONE;
            else if (rev) dlt_d = -S_ONE;
            else          dlt_d = '0;
        end else if (fwd || rev) begin
            dlt_d = sat_step(dlt_q, fwd);
        end

        if (fwd) begin
            right_d = 1'b1;
            left_d  = 1'b0;
            hold_d  = HOLD_LD;
        end else if (rev) begin
            right_d = 1'b0;
            left_d  = 1'b1;
            hold_d  = HOLD_LD;
        end else if (hold_q != '0) begin
            hold_d = hold_q - HT_W'(1);
            if (hold_q == HT_W'(1)) begin
                right_d = 1'b0;
                left_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        sync1_q <= {steerA, steerB};
        sync2_q <= sync1_q;
        if (RESET) begin
            // Track the pins during reset so release at rest decodes no step.
            filt_q  <= sync2_q;
            prev_q  <= sync2_q;
            fcnt_q  <= '0;
            pos_q   <= '0;
            dlt_q   <= '0;
            hold_q  <= '0;
            step_q  <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            fcnt_q  <= fcnt_d;
            pos_q   <= pos_d;
            dlt_q   <= dlt_d;
            hold_q  <= hold_d;
            step_q  <= fwd | rev;
            left_q  <= left_d;
            right_q <= right_d;
            err_q   <= err_d;
        end
    end

    assign position = pos_q;
    assign delta    = dlt_q;
    assign step     = step_q;
    assign c_left   = left_q;
    assign c_right  = right_q;
    assign err      = err_q;
endmodule

// File: tb/tb_quad2joy.sv
// Scoreboard bench for quad2joy: directed encoder steps push expected step
// records; a negedge monitor pops and compares on every step pulse.
module tb_quad2joy;
    localparam int FILT_LEN = 4;
    localparam int HOLD     = 8;
    localparam int CNT_W    = 8;
    localparam int LAT      = 2 + FILT_LEN + 1;

    logic       CLK = 1'b0;
    logic       RESET, steerA, steerB, clr;
    logic [7:0] position, delta;
    logic       step, c_left, c_right, err;

    typedef struct {
        int         cyc;
        logic [7:0] pos;
        logic [7:0] dl;
        logic       right;
        logic       left;
    } exp_t;

    exp_t       sbq[$];
    exp_t       mon_e;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] ab;
    int         m_pos, m_dlt;

    quad2joy #(.FILT_LEN(FILT_LEN), .HOLD(HOLD), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .steerA(steerA), .steerB(steerB), .clr(clr),
        .position(position), .delta(delta), .step(step),
        .c_left(c_left), .c_right(c_right), .err(err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(2);
        chk("rst_position", position, 8'h00);
        chk("rst_delta", delta, 8'h00);
        chk("rst_step", step, 1'b0);
        chk("rst_c_left", c_left, 1'b0);
        chk("rst_c_right", c_right, 1'b0);
        chk("rst_err", err, 1'b0);
        m_pos = 0;
        m_dlt = 0;
        RESET = 1'b0;
        tick(2);
    endtask

    // Move the encoder one detent and queue the step the DUT must report.
    task automatic do_step(input int dir, input bit with_clr);
        exp_t       e;
        logic [1:0] idx;
        logic [1:0] d2;
        d2  = (dir > 0) ? 2'd1 : 2'd3;
        idx = {ab[1], ab[1] ^ ab[0]} + d2;
        ab  = {idx[1], idx[1] ^ idx[0]};
        m_pos = (m_pos + dir) & 255;
        if (with_clr) begin
            m_dlt = dir;
        end else begin
            m_dlt = m_dlt + dir;
            if (m_dlt > 127)  m_dlt = 127;
            if (m_dlt < -128) m_dlt = -128;
        end
        e.cyc   = cyc + LAT;
        e.pos   = m_pos[7:0];
        e.dl    = m_dlt[7:0];
        e.right = (dir > 0);
        e.left  = (dir < 0);
        sbq.push_back(e);
        steerA = ab[1];
        steerB = ab[0];
        if (with_clr) begin
            tick(LAT - 1);
            clr = 1'b1;
            tick(1);
            clr = 1'b0;
        end
    endtask

    always @(negedge CLK) begin
        if (step === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_step: got step=1 with no step queued (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("step_cycle", cyc, mon_e.cyc);
                chk("step_position", position, mon_e.pos);
                chk("step_delta", delta, mon_e.dl);
                chk("step_c_right", c_right, mon_e.right);
                chk("step_c_left", c_left, mon_e.left);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int hi_cnt;
        RESET  = 1'b1;
        steerA = 1'b0;
        steerB = 1'b0;
        clr    = 1'b0;
        ab     = 2'b00;
        m_pos  = 0;
        m_dlt  = 0;
        tick(2);
        do_reset();
        tick(3);

        // Four forward steps, 20 cycles apart
        for (int i = 0; i < 4; i++) begin
            do_step(1, 1'b0);
            tick(20);
        end
        chk("fwd4_position", position, 8'h04);
        chk("fwd4_delta", delta, 8'h04);
        chk("fwd4_err", err, 1'b0);

        // 3-cycle glitch on A must be filtered out
        steerA = 1'b1;
        tick(3);
        steerA = 1'b0;
        tick(20);
        chk("glitch_position", position, 8'h04);
        chk("glitch_delta", delta, 8'h04);
        chk("glitch_c_left", c_left, 1'b0);
        chk("glitch_c_right", c_right, 1'b0);

        // One reverse step from reset, c_left held for HOLD cycles
        do_reset();
        do_step(-1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (c_left === 1'b1) break;
        end
        hi_cnt = 0;
        while (c_left === 1'b1 && hi_cnt < 30) begin
            hi_cnt++;
            @(negedge CLK);
        end
        chk("rev_c_left_cycles", hi_cnt, HOLD);
        tick(2);
        chk("rev_position", position, 8'hFF);
        chk("rev_delta", delta, 8'hFF);
        chk("rev_c_right", c_right, 1'b0);

        // 130 forward steps: position wraps freely, delta saturates
        do_reset();
        for (int i = 0; i < 130; i++) begin
            do_step(1, 1'b0);
            tick(12);
        end
        chk("sat_position", position, 8'h82);
        chk("sat_delta", delta, 8'h7F);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        m_dlt = 0;
        chk("clr_delta", delta, 8'h00);
        chk("clr_position", position, 8'h82);

        // Both phases flip together: illegal, sticky err, no step
        ab = ab ^ 2'b11;
        steerA = ab[1];
        steerB = ab[0];
        tick(12);
        chk("illegal_err", err, 1'b1);
        chk("illegal_position", position, 8'h82);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("illegal_err_after_clr", err, 1'b1);
        do_step(1, 1'b0);
        tick(12);
        chk("post_illegal_position", position, 8'h83);
        chk("post_illegal_delta", delta, 8'h01);
        chk("post_illegal_err", err, 1'b1);
        do_reset();

        // clr coincident with a reverse step, then RESET while c_right is high
        do_step(1, 1'b0);
        tick(12);
        do_step(1, 1'b0);
        tick(12);
        do_step(-1, 1'b1);
        tick(12);
        chk("clr_rev_delta", delta, 8'hFF);
        chk("clr_rev_position", position, 8'h01);
        do_step(1, 1'b0);
        tick(LAT);
        chk("pre_reset_c_right", c_right, 1'b1);
        RESET = 1'b1;
        tick(1);
        chk("midrst_position", position, 8'h00);
        chk("midrst_delta", delta, 8'h00);
        chk("midrst_step", step, 1'b0);
        chk("midrst_c_right", c_right, 1'b0);
        chk("midrst_c_left", c_left, 1'b0);
        chk("midrst_err", err, 1'b0);
        tick(1);
        RESET = 1'b0;
        m_pos = 0;
        m_dlt = 0;
        tick(20);
        chk("release_position", position, 8'h00);
        chk("release_c_right", c_right, 1'b0);

        chk("queue_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
